// File: rtl/seq_div_sub.sv
// seq_div_sub: sequential unsigned divider with a start/busy/done handshake.
// Define DIV_FAST_EN for N-edge restoring shift-subtract instead of repeated subtraction.
module seq_div_sub #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] dvs_q, dvs_d;
  logic [N-1:0] quo_q, quo_d;
  logic [N-1:0] rem_q, rem_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         dz;
  logic         fin;

  assign dz = (dvs_q == '0);

`ifdef DIV_FAST_EN
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [N:0]    trial;
  logic          ge;
  logic [N-1:0]  step_acc;
  logic [N-1:0]  step_sh;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign trial    = {acc_q, sh_q[N-1]};
  assign ge       = (trial >= {1'b0, dvs_q});
  assign step_acc = ge ? N'(trial - {1'b0, dvs_q}) : trial[N-1:0];
  assign step_sh  = {sh_q[N-2:0], ge};
  assign fin      = (cnt_q == CW'(N - 1));
`else
  assign fin = (rem_q < dvs_q);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef DIV_FAST_EN
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef DIV_FAST_EN
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (dz || fin) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d  = err_q;
`ifdef DIV_FAST_EN
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    sh_d   = sh_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dvs_d  = divisor;
          rem_d  = dividend;
          quo_d  = '0;
          err_d  = 1'b0;
          busy_d = 1'b1;
`ifdef DIV_FAST_EN
          cnt_d  = '0;
          acc_d  = '0;
          sh_d   = dividend;
`endif
        end
      end
      S_RUN: begin
        if (dz) begin
          quo_d  = '1;
          err_d  = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
`ifdef DIV_FAST_EN
          cnt_d = cnt_q + CW'(1);
          acc_d = step_acc;
          sh_d  = step_sh;
          if (fin) begin
            quo_d  = step_sh;
            rem_d  = step_acc;
            busy_d = 1'b0;
            done_d = 1'b1;
          end
`else
          if (fin) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            rem_d = rem_q - dvs_q;
            quo_d = quo_q + N'(1);
          end
`endif
        end
      end
      default: done_d = 1'b0;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_div_sub.sv
// tb_seq_div_sub: directed scoreboard bench for seq_div_sub (default build).
// Expected results are queued at start and checked when done pulses.
module tb_seq_div_sub;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       err;

  seq_div_sub #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
    int         e0;
    int         de;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;
  int   e0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] q, input logic [7:0] r,
                          input logic e, input int s, input int de);
    exp_t x;
    x.q  = q;
    x.r  = r;
    x.e  = e;
    x.e0 = s;
    x.de = de;
    sb.push_back(x);
  endtask

  // Drives a start; returns the accepting edge number.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                          input bit hold, output int s);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    s        = edge_n + 1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int   ein;
    int   bcnt;
    bit   seen;
    int   first;
    exp_t x;
    ein  = edge_n;
    bcnt = 0;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (busy === 1'b1) bcnt++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    x = sb.pop_front();
    first = (x.e0 > ein) ? x.e0 : ein;
    chk({tag, "_quotient"}, 32'(quotient), 32'(x.q));
    chk({tag, "_remainder"}, 32'(remainder), 32'(x.r));
    chk({tag, "_err"}, 32'(err), 32'(x.e));
    chk({tag, "_done_edge"}, 32'(edge_n), 32'(x.de));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(x.de - first));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit any_done;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);

    start_op(8'd17, 8'd5, 1'b0, e0);
    push_exp(8'd3, 8'd2, 1'b0, e0, e0 + 4);
    wait_done("d17_5");

    start_op(8'd8, 8'd0, 1'b0, e0);
    push_exp(8'hFF, 8'd8, 1'b1, e0, e0 + 1);
    wait_done("d8_0");

    start_op(8'd3, 8'd9, 1'b0, e0);
    push_exp(8'd0, 8'd3, 1'b0, e0, e0 + 1);
    wait_done("d3_9");

    start_op(8'd9, 8'd9, 1'b0, e0);
    push_exp(8'd1, 8'd0, 1'b0, e0, e0 + 2);
    wait_done("d9_9");

    start_op(8'd255, 8'd1, 1'b0, e0);
    push_exp(8'd255, 8'd0, 1'b0, e0, e0 + 256);
    for (int i = 0; i < 20; i++) begin
      start    = i[0];
      dividend = 8'd7 + 8'(i);
      divisor  = 8'd3;
      tick();
    end
    start = 1'b0;
    wait_done("d255_1");
    repeat (3) @(negedge clk);
    chk("d255_1_idle_busy", 32'(busy), 32'd0);

    start_op(8'd200, 8'd1, 1'b0, e0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    any_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) any_done = 1;
    end
    chk("abort_no_done", 32'(any_done), 32'd0);

    start_op(8'd24, 8'd8, 1'b0, e0);
    push_exp(8'd3, 8'd0, 1'b0, e0, e0 + 4);
    wait_done("d24_8");

    start_op(8'd24, 8'd3, 1'b1, e0);
    push_exp(8'd8, 8'd0, 1'b0, e0, e0 + 9);
    push_exp(8'd8, 8'd0, 1'b0, e0 + 11, e0 + 20);
    wait_done("hold_first");
    wait_done("hold_second");
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_idle_busy", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
